// File: rtl/mul_arbiter_if.sv
// rtl/mul_arbiter_if.sv - request/response bus between client blocks and the shared multiplier
interface mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic [2*WIDTH-1:0]       resp_product;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_product
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_product
    );
endinterface

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin arbiter sharing one shift-add multiplier; MUL_ARB_EARLY_EXIT_EN ends BUSY once the multiplier runs out of set bits
module mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
) (
    input  logic         clk,
    input  logic         rst,
    mul_arbiter_if.slave bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    cur_id;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic [NUM_REQ-1:0] grant;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [PW-1:0]      a_sh;
    logic [PW-1:0]      acc;
    logic [PW-1:0]      acc_next;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   b_next;
    logic [CNT_W-1:0]   count;
    logic               last_iter;

    // Lowest index at or above the pointer wins; otherwise the lowest index below it.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (i < int'(ptr))) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_id  = ID_W'(i);
                grant_any = 1'b1;
                sel_a     = bus.req_a[i*WIDTH +: WIDTH];
                sel_b     = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (i >= int'(ptr))) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_id  = ID_W'(i);
                grant_any = 1'b1;
                sel_a     = bus.req_a[i*WIDTH +: WIDTH];
                sel_b     = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.req_ready = (state == IDLE) ? grant : '0;

    assign acc_next = b_sh[0] ? (acc + a_sh) : acc;
    assign b_next   = b_sh >> 1;

`ifdef MUL_ARB_EARLY_EXIT_EN
    assign last_iter = (count == CNT_W'(WIDTH - 1)) || (b_next == '0);
`else
    assign last_iter = (count == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ptr              <= '0;
            cur_id           <= '0;
            a_sh             <= '0;
            b_sh             <= '0;
            acc              <= '0;
            count            <= '0;
            bus.resp_valid   <= 1'b0;
            bus.resp_id      <= '0;
            bus.resp_product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        a_sh   <= {{WIDTH{1'b0}}, sel_a};
                        b_sh   <= sel_b;
                        acc    <= '0;
                        count  <= '0;
                        cur_id <= grant_id;
                        ptr    <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    a_sh  <= a_sh << 1;
                    b_sh  <= b_next;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        bus.resp_valid   <= 1'b1;
                        bus.resp_product <= acc_next;
                        bus.resp_id      <= cur_id;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - scoreboard bench for mul_arbiter: arbitration order, latency, products, backpressure, reset
module tb_mul_arbiter;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int ID_W    = 2;
    localparam int EW      = ID_W + 2 * WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();
    mul_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int              n_assert = 0;
    int              n_fail   = 0;
    logic [EW-1:0]   sb[$];
    logic [EW-1:0]   exp_e;
    int              accept_cyc;
    int              resp_cyc;
    bit              ok;

    function automatic logic [2*WIDTH-1:0] mul_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = '0;
        for (int k = 0; k < WIDTH; k++)
            if (b[k]) p = p + ({{WIDTH{1'b0}}, a} << k);
        return p;
    endfunction

    function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef MUL_ARB_EARLY_EXIT_EN
        int m;
        m = 0;
        for (int k = 0; k < WIDTH; k++)
            if (b[k]) m = k + 1;
        return (m == 0) ? 1 : m;
`else
        return WIDTH;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.resp_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.req_a[i*WIDTH +: WIDTH] = a;
        bus.req_b[i*WIDTH +: WIDTH] = b;
    endtask

    // Raise valid on requester i, wait for its grant, record the expected result at the accept edge.
    task automatic issue(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output bit okay);
        okay = 1'b0;
        set_op(i, a, b);
        bus.req_valid[i] = 1'b1;
        #1;
        for (int n = 0; n < 40; n++) begin
            if (bus.req_ready[i] === 1'b1) begin
                sb.push_back({ID_W'(i), mul_model(a, b)});
                step();
                accept_cyc = cyc;
                bus.req_valid[i] = 1'b0;
                okay = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_resp(output bit okay);
        okay = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.resp_valid === 1'b1) begin
                resp_cyc = cyc;
                okay = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        n_assert++;
        if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %0h expected 0", bus.resp_valid); end
        n_assert++;
        if (bus.resp_id !== '0) begin n_fail++; $display("FAIL reset_resp_id: got %0h expected 0", bus.resp_id); end
        n_assert++;
        if (bus.resp_product !== '0) begin n_fail++; $display("FAIL reset_resp_product: got %0h expected 0", bus.resp_product); end
        n_assert++;
        if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready_idle: got %b expected 0000", bus.req_ready); end
        bus.req_valid = 4'b1111;
        #1;
        n_assert++;
        if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_priority: got %b expected 0001", bus.req_ready); end
        bus.req_valid = '0;
        bus.resp_ready = 1'b1;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        set_op(3, 8'h0C, 8'h0A);
        bus.req_valid[3] = 1'b1;
        #1;
        n_assert++;
        if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL single_ready_same_cycle: got %b expected 1000", bus.req_ready); end
        issue(3, 8'h0C, 8'h0A, ok);
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL single_accept: got timeout expected grant"); end
        wait_resp(ok);
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL single_resp: got timeout expected resp_valid"); end
        n_assert++;
        if (resp_cyc - accept_cyc != exp_lat(8'h0A)) begin
            n_fail++; $display("FAIL single_latency: got %0d expected %0d", resp_cyc - accept_cyc, exp_lat(8'h0A));
        end
        n_assert++;
        if (bus.resp_product !== 16'h0078 || bus.resp_id !== 2'd3) begin
            n_fail++; $display("FAIL single_const: got id %0d prod %h expected id 3 prod 0078", bus.resp_id, bus.resp_product);
        end
        n_assert++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL single_sb: got empty queue expected entry"); end
        else begin
            exp_e = sb.pop_front();
            if ({bus.resp_id, bus.resp_product} !== exp_e) begin
                n_fail++; $display("FAIL single_sb: got %h expected %h", {bus.resp_id, bus.resp_product}, exp_e);
            end
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [WIDTH-1:0] ta[4];
        logic [WIDTH-1:0] tb_[4];
        int order[5];
        int gid;
        int prev_cyc;
        int prev_id;
        ta  = '{8'h13, 8'h2A, 8'hC5, 8'h7E};
        tb_ = '{8'h9B, 8'h04, 8'hE7, 8'h60};
        order = '{0, 1, 2, 3, 0};
        prev_cyc = 0;
        prev_id  = 0;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, ta[i], tb_[i]);
        bus.req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            ok = 1'b0;
            for (int n = 0; n < 40; n++) begin
                if (bus.req_ready !== 4'b0000) begin ok = 1'b1; break; end
                step();
            end
            n_assert++;
            if (!ok) begin n_fail++; $display("FAIL rr_grant_%0d: got timeout expected grant", g); break; end
            gid = -1;
            for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i] === 1'b1) gid = i;
            n_assert++;
            if (gid != order[g]) begin n_fail++; $display("FAIL rr_order_%0d: got %0d expected %0d", g, gid, order[g]); end
            if (gid < 0) break;
            sb.push_back({ID_W'(gid), mul_model(ta[gid], tb_[gid])});
            step();
            accept_cyc = cyc;
            if (g > 0) begin
                n_assert++;
                if (accept_cyc - prev_cyc != exp_lat(tb_[prev_id]) + 2) begin
                    n_fail++; $display("FAIL rr_spacing_%0d: got %0d expected %0d", g, accept_cyc - prev_cyc, exp_lat(tb_[prev_id]) + 2);
                end
            end
            prev_cyc = accept_cyc;
            prev_id  = gid;
            wait_resp(ok);
            n_assert++;
            if (!ok) begin n_fail++; $display("FAIL rr_resp_%0d: got timeout expected resp_valid", g); break; end
            n_assert++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL rr_sb_%0d: got empty queue expected entry", g); end
            else begin
                exp_e = sb.pop_front();
                if ({bus.resp_id, bus.resp_product} !== exp_e) begin
                    n_fail++; $display("FAIL rr_sb_%0d: got %h expected %h", g, {bus.resp_id, bus.resp_product}, exp_e);
                end
            end
            step();
        end
        bus.req_valid = '0;
        step();
    endtask

    task automatic test_boundary();
        logic [WIDTH-1:0]   ta[3];
        logic [WIDTH-1:0]   tb_[3];
        logic [2*WIDTH-1:0] tp[3];
        ta  = '{8'hFF, 8'h00, 8'hFF};
        tb_ = '{8'hFF, 8'hFF, 8'h01};
        tp  = '{16'hFE01, 16'h0000, 16'h00FF};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            issue(0, ta[c], tb_[c], ok);
            n_assert++;
            if (!ok) begin n_fail++; $display("FAIL bnd_accept_%0d: got timeout expected grant", c); break; end
            wait_resp(ok);
            n_assert++;
            if (!ok) begin n_fail++; $display("FAIL bnd_resp_%0d: got timeout expected resp_valid", c); break; end
            n_assert++;
            if (resp_cyc - accept_cyc != exp_lat(tb_[c])) begin
                n_fail++; $display("FAIL bnd_latency_%0d: got %0d expected %0d", c, resp_cyc - accept_cyc, exp_lat(tb_[c]));
            end
            n_assert++;
            if (bus.resp_product !== tp[c]) begin
                n_fail++; $display("FAIL bnd_const_%0d: got %h expected %h", c, bus.resp_product, tp[c]);
            end
            n_assert++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL bnd_sb_%0d: got empty queue expected entry", c); end
            else begin
                exp_e = sb.pop_front();
                if ({bus.resp_id, bus.resp_product} !== exp_e) begin
                    n_fail++; $display("FAIL bnd_sb_%0d: got %h expected %h", c, {bus.resp_id, bus.resp_product}, exp_e);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.resp_ready = 1'b0;
        issue(1, 8'hA5, 8'h3C, ok);
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL bp_accept: got timeout expected grant"); end
        wait_resp(ok);
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL bp_resp: got timeout expected resp_valid"); end
        set_op(2, 8'h21, 8'h0F);
        bus.req_valid[2] = 1'b1;
        exp_e = (sb.size() != 0) ? sb.pop_front() : '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_assert++;
            if (bus.resp_valid !== 1'b1 || {bus.resp_id, bus.resp_product} !== exp_e || bus.req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got valid %0h data %h ready %b expected valid 1 data %h ready 0000",
                         k, bus.resp_valid, {bus.resp_id, bus.resp_product}, bus.req_ready, exp_e);
            end
            step();
        end
        bus.resp_ready = 1'b1;
        step();
        n_assert++;
        if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %0h expected 0", bus.resp_valid); end
        n_assert++;
        if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 0100", bus.req_ready); end
        issue(2, 8'h21, 8'h0F, ok);
        wait_resp(ok);
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL bp_next_resp: got timeout expected resp_valid"); end
        else if (sb.size() == 0) begin n_fail++; $display("FAIL bp_next_sb: got empty queue expected entry"); end
        else begin
            exp_e = sb.pop_front();
            if ({bus.resp_id, bus.resp_product} !== exp_e) begin
                n_fail++; $display("FAIL bp_next_sb: got %h expected %h", {bus.resp_id, bus.resp_product}, exp_e);
            end
        end
        step();
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        issue(2, 8'h5A, 8'hC3, ok);
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL rmb_accept: got timeout expected grant"); end
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        n_assert++;
        if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rmb_resp_valid: got %0h expected 0", bus.resp_valid); end
        set_op(1, 8'h9D, 8'h47);
        set_op(2, 8'h5A, 8'hC3);
        bus.req_valid[1] = 1'b1;
        bus.req_valid[2] = 1'b1;
        #1;
        n_assert++;
        if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL rmb_ptr: got %b expected 0010", bus.req_ready); end
        issue(1, 8'h9D, 8'h47, ok);
        bus.req_valid[2] = 1'b0;
        wait_resp(ok);
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL rmb_resp: got timeout expected resp_valid"); end
        n_assert++;
        if (resp_cyc - accept_cyc != exp_lat(8'h47)) begin
            n_fail++; $display("FAIL rmb_latency: got %0d expected %0d", resp_cyc - accept_cyc, exp_lat(8'h47));
        end
        n_assert++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL rmb_sb: got empty queue expected entry"); end
        else begin
            exp_e = sb.pop_front();
            if ({bus.resp_id, bus.resp_product} !== exp_e) begin
                n_fail++; $display("FAIL rmb_sb: got %h expected %h", {bus.resp_id, bus.resp_product}, exp_e);
            end
        end
        step();
    endtask

    task automatic test_early_exit();
        logic [WIDTH-1:0]   tb_[3];
        logic [2*WIDTH-1:0] tp[3];
        int                 tl[3];
        tb_ = '{8'h01, 8'h05, 8'h00};
        tp  = '{16'h0037, 16'h0113, 16'h0000};
`ifdef MUL_ARB_EARLY_EXIT_EN
        tl  = '{1, 3, 1};
`else
        tl  = '{8, 8, 8};
`endif
        do_reset();
        for (int c = 0; c < 3; c++) begin
            issue(3, 8'h37, tb_[c], ok);
            wait_resp(ok);
            n_assert++;
            if (!ok) begin n_fail++; $display("FAIL ee_resp_%0d: got timeout expected resp_valid", c); break; end
            n_assert++;
            if (resp_cyc - accept_cyc != tl[c]) begin
                n_fail++; $display("FAIL ee_latency_%0d: got %0d expected %0d", c, resp_cyc - accept_cyc, tl[c]);
            end
            n_assert++;
            if (bus.resp_product !== tp[c]) begin
                n_fail++; $display("FAIL ee_product_%0d: got %h expected %h", c, bus.resp_product, tp[c]);
            end
            n_assert++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL ee_sb_%0d: got empty queue expected entry", c); end
            else begin
                exp_e = sb.pop_front();
                if ({bus.resp_id, bus.resp_product} !== exp_e) begin
                    n_fail++; $display("FAIL ee_sb_%0d: got %h expected %h", c, {bus.resp_id, bus.resp_product}, exp_e);
                end
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_boundary();
        test_backpressure();
        test_reset_mid_busy();
        test_early_exit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
